// File: rtl/servo_cmd_sequencer.sv
// Scans n_channels servo duty registers, presenting each on address/duty_cycle_value
// for one slot of slot_cycles clocks with a latch strobe, fed by a host-written clamped shadow bank.
module servo_cmd_sequencer #(
    parameter int         n_channels     = 4,
    parameter int         addr_bus_width = 2,
    parameter int         slot_cycles    = 250000,
    parameter logic [7:0] duty_min       = 8'd0,
    parameter logic [7:0] duty_max       = 8'd255,
    parameter logic [7:0] duty_rst       = 8'd128
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      wr_en,
    input  logic [addr_bus_width-1:0] wr_addr,
    input  logic [7:0]                wr_data,
    output logic [addr_bus_width-1:0] address,
    output logic [7:0]                duty_cycle_value,
    output logic                      latch,
    output logic                      frame_start,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, LOAD, LATCH, HOLD} state_t;

    localparam logic [addr_bus_width:0]   NCH_W     = (addr_bus_width+1)'(n_channels);
    localparam logic [addr_bus_width-1:0] LAST_CH   = addr_bus_width'(n_channels - 1);
    // LOAD and LATCH take one cycle each; HOLD fills the rest of the slot.
    localparam logic [23:0]               HOLD_LAST = 24'(slot_cycles - 3);

    state_t                                state_q;
    logic [addr_bus_width-1:0]             idx_q, idx_d;
    logic [23:0]                           cnt_q;
    logic [addr_bus_width-1:0]             addr_q;
    logic [7:0]                            duty_q;
    logic                                  latch_q, frame_q, busy_q;
    logic [n_channels-1:0][7:0]            shadow_q;
    logic [7:0]                            clamp_d;

    always_comb begin
        clamp_d = wr_data;
        if (wr_data <= duty_min)
            clamp_d = duty_min;
        else if (wr_data >= duty_max)
            clamp_d = duty_max;
    end

    always_comb begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_CH)
            idx_d = '0;
    end

    // Writes in a channel's LOAD cycle land after duty_q has sampled the old value.
    always_ff @(posedge clk) begin
        if (!reset_n)
            shadow_q <= {n_channels{duty_rst}};
        else if (wr_en && ({1'b0, wr_addr} < NCH_W))
            shadow_q[wr_addr] <= clamp_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            duty_q  <= '0;
            latch_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            latch_q <= 1'b0;
            frame_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    addr_q  <= idx_q;
                    duty_q  <= shadow_q[idx_q];
                    latch_q <= 1'b1;
                    frame_q <= (idx_q == '0);
                    state_q <= LATCH;
                end
                LATCH: begin
                    cnt_q   <= '0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        idx_q <= idx_d;
                        if (enable) begin
                            state_q <= LOAD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign address          = addr_q;
    assign duty_cycle_value = duty_q;
    assign latch            = latch_q;
    assign frame_start      = frame_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Bench for servo_cmd_sequencer: directed scenarios plus randomized traffic checked
// against a slot-position reference model.
module tb_servo_cmd_sequencer;

    localparam int         NCH  = 4;
    localparam int         SLOT = 8;
    localparam logic [7:0] DMIN = 8'd20;
    localparam logic [7:0] DMAX = 8'd200;
    localparam logic [7:0] DRST = 8'd128;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0, enable = 1'b0, wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] address;
    logic [7:0] duty_cycle_value;
    logic       latch, frame_start, busy;

    int vecs = 0;
    int errs = 0;

    // Reference model: position within the current slot (0 = LOAD cycle).
    bit         m_run = 0;
    int         m_pos = 0;
    int         m_ch  = 0;
    logic [1:0] m_addr = '0;
    logic [7:0] m_dcv  = '0;
    logic [7:0] m_sh [NCH];

    servo_cmd_sequencer #(
        .n_channels(NCH), .addr_bus_width(2), .slot_cycles(SLOT),
        .duty_min(DMIN), .duty_max(DMAX), .duty_rst(DRST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .address(address),
        .duty_cycle_value(duty_cycle_value), .latch(latch),
        .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] expv();
        logic l;
        l = m_run && (m_pos == 1);
        return {m_addr, m_dcv, l, l && (m_ch == 0), logic'(m_run)};
    endfunction

    function automatic logic [12:0] obsv();
        return {address, duty_cycle_value, latch, frame_start, busy};
    endfunction

    task automatic step(input logic rn, input logic en, input logic we,
                        input logic [1:0] wa, input logic [7:0] wd);
        reset_n = rn; enable = en; wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        if (!rn) begin
            m_run = 0; m_pos = 0; m_ch = 0; m_addr = '0; m_dcv = '0;
            for (int i = 0; i < NCH; i++) m_sh[i] = DRST;
        end else begin
            if (!m_run) begin
                if (en) begin m_run = 1; m_pos = 0; m_ch = 0; end
            end else if (m_pos == 0) begin
                m_addr = 2'(m_ch); m_dcv = m_sh[m_ch]; m_pos = 1;
            end else if (m_pos == SLOT - 1) begin
                m_ch = (m_ch + 1) % NCH;
                if (en) m_pos = 0; else m_run = 0;
            end else begin
                m_pos++;
            end
            if (we && int'(wa) < NCH)
                m_sh[wa] = (wd < DMIN) ? DMIN : (wd > DMAX) ? DMAX : wd;
        end
        #1;
    endtask

    task automatic wait_latch(input int want, output bit ok);
        ok = 0;
        for (int n = 0; n < 5 * SLOT && !ok; n++) begin
            step(1, 1, 0, 0, 0);
            if (latch === 1'b1 && int'(address) == want) ok = 1;
        end
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 2'd1, 8'd99);
        vecs++;
        if (obsv() !== 13'd0) begin
            errs++; $display("FAIL reset_state got %h want 0", obsv());
        end
        vecs++;
        if (obsv() !== expv()) begin
            errs++; $display("FAIL reset_model got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_default_scan();
        int q[$];
        int last = -1;
        for (int n = 0; n < 40; n++) begin
            step(1, 1, 0, 0, 0);
            vecs++;
            if (obsv() !== expv()) begin
                errs++; $display("FAIL scan_vec cyc %0d got %h want %h", n, obsv(), expv());
            end
            if (latch === 1'b1) begin
                q.push_back(int'(address));
                vecs++;
                if (duty_cycle_value !== DRST || frame_start !== (address == 2'd0)) begin
                    errs++; $display("FAIL scan_duty got %0d/%b want %0d/%b",
                        duty_cycle_value, frame_start, DRST, address == 2'd0);
                end
                if (last >= 0) begin
                    vecs++;
                    if (n - last != SLOT) begin
                        errs++; $display("FAIL scan_period got %0d want %0d", n - last, SLOT);
                    end
                end
                last = n;
            end
        end
        vecs++;
        if (q.size() != 5 || q[0] != 0 || q[1] != 1 || q[2] != 2 || q[3] != 3 || q[4] != 0) begin
            errs++; $display("FAIL scan_order got %p want 0,1,2,3,0", q);
        end
    endtask

    task automatic test_clamp();
        bit ok;
        logic [7:0] want;
        wait_latch(0, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL clamp_wait got timeout want latch"); end
        step(1, 1, 1, 2'd2, 8'd250);
        step(1, 1, 1, 2'd1, 8'd5);
        step(1, 1, 1, 2'd3, 8'd90);
        for (int n = 0; n < 32; n++) begin
            step(1, 1, 0, 0, 0);
            vecs++;
            if (obsv() !== expv()) begin
                errs++; $display("FAIL clamp_vec got %h want %h", obsv(), expv());
            end
            if (latch === 1'b1) begin
                case (address)
                    2'd1: want = 8'd20;
                    2'd2: want = 8'd200;
                    2'd3: want = 8'd90;
                    default: want = 8'd128;
                endcase
                vecs++;
                if (duty_cycle_value !== want) begin
                    errs++; $display("FAIL clamp_ch%0d got %0d want %0d", address, duty_cycle_value, want);
                end
            end
        end
    endtask

    task automatic test_load_write();
        bit ok;
        wait_latch(0, ok);
        repeat (SLOT - 1) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 2'd1, 8'd77);
        vecs++;
        if (!ok || latch !== 1'b1 || address !== 2'd1 || duty_cycle_value !== 8'd20) begin
            errs++; $display("FAIL loadwr_cur got %b/%0d/%0d want 1/1/20", latch, address, duty_cycle_value);
        end
        wait_latch(1, ok);
        vecs++;
        if (!ok || duty_cycle_value !== 8'd77) begin
            errs++; $display("FAIL loadwr_next got %0d want 77", duty_cycle_value);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit seen = 0;
        wait_latch(2, ok);
        step(1, 1, 0, 0, 0);
        for (int n = 0; n < 5; n++) step(1, 0, 0, 0, 0);
        vecs++;
        if (!ok || busy !== 1'b1) begin
            errs++; $display("FAIL drop_busy_hold got %b want 1", busy);
        end
        step(1, 0, 0, 0, 0);
        vecs++;
        if (busy !== 1'b0 || latch !== 1'b0) begin
            errs++; $display("FAIL drop_busy_fall got %b/%b want 0/0", busy, latch);
        end
        for (int n = 0; n < 10; n++) begin
            step(1, 0, 0, 0, 0);
            if (latch !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        vecs++;
        if (seen) begin errs++; $display("FAIL drop_idle got activity want none"); end
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        vecs++;
        if (latch !== 1'b1 || address !== 2'd0 || frame_start !== 1'b1) begin
            errs++; $display("FAIL drop_restart got %b/%0d/%b want 1/0/1", latch, address, frame_start);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_latch(1, ok);
        step(1, 1, 1, 2'd0, 8'd50);
        step(1, 1, 1, 2'd0, 8'd60);
        wait_latch(0, ok);
        vecs++;
        if (!ok || duty_cycle_value !== 8'd60) begin
            errs++; $display("FAIL b2b_ch0 got %0d want 60", duty_cycle_value);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_latch(3, ok);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 2'd0, 8'd50);
        vecs++;
        if (!ok || obsv() !== 13'd0) begin
            errs++; $display("FAIL rstmid_out got %h want 0", obsv());
        end
        for (int c = 0; c < NCH; c++) begin
            wait_latch(c, ok);
            vecs++;
            if (!ok || duty_cycle_value !== DRST) begin
                errs++; $display("FAIL rstmid_ch%0d got %0d want %0d", c, duty_cycle_value, DRST);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            step(logic'($urandom_range(0, 149) != 0), logic'($urandom_range(0, 9) != 0),
                 logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            vecs++;
            if (obsv() !== expv()) begin
                errs++; $display("FAIL rand_vec cyc %0d got %h want %h", n, obsv(), expv());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) m_sh[i] = DRST;
        test_reset();
        test_default_scan();
        test_clamp();
        test_load_write();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/servo_cmd_sequencer.md
SERVO_CMD_SEQUENCER -- requirements
Module: servo_cmd_sequencer

Parameters
REQ-001 n_channels, default 4, number of servo channels scanned.
REQ-002 addr_bus_width, default 2, channel address width; SHALL satisfy 2^addr_bus_width >= n_channels.
REQ-003 slot_cycles, default 250000, clk cycles per channel slot (5 ms at 50 MHz); legal range 4..2^24-1.
REQ-004 duty_min, default 8'd0, lower clamp bound for written duty.
REQ-005 duty_max, default 8'd255, upper clamp bound for written duty; duty_min <= duty_max.
REQ-006 duty_rst, default 8'd128, reset value of every shadow duty register.

Interface
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 reset_n  input  1  reset is synchronous and active-low.
REQ-009 enable  input  1  level; 1 = run channel scan.
REQ-010 wr_en  input  1  host write strobe, one write per cycle.
REQ-011 wr_addr  input  addr_bus_width  channel index of the host write.
REQ-012 wr_data  input  8  requested duty value.
REQ-013 address  output  addr_bus_width  channel currently being driven downstream.
REQ-014 duty_cycle_value  output  8  duty for the current channel.
REQ-015 latch  output  1  one-cycle strobe; downstream captures duty_cycle_value on it.
REQ-016 frame_start  output  1  one-cycle pulse coincident with the channel 0 latch.
REQ-017 busy  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-018 Shadow bank: n_channels x 8-bit registers; a write with wr_en=1 and wr_addr<n_channels SHALL update the register on that edge, visible from the next cycle.
REQ-019 Writes with wr_addr>=n_channels SHALL be ignored.
REQ-020 Stored value = clamp(wr_data, duty_min, duty_max), computed unsigned, 8-bit.
REQ-021 FSM states: IDLE, LOAD, LATCH, HOLD.
REQ-022 IDLE: latch=0, busy=0, outputs hold their last values; enable=1 -> LOAD with channel index 0.
REQ-023 LOAD (1 cycle): address <= channel index, duty_cycle_value <= shadow[index] sampled this cycle; -> LATCH.
REQ-024 LATCH (1 cycle): latch=1, frame_start=1 iff index==0; slot counter cleared; -> HOLD.
REQ-025 HOLD: count slot_cycles-2 cycles, so each slot spans exactly slot_cycles clocks from LOAD entry to next LOAD entry.
REQ-026 At HOLD end: index wraps n_channels-1 -> 0, otherwise increments; enable=1 -> LOAD, enable=0 -> IDLE.
REQ-027 enable deassertion mid-slot SHALL NOT truncate the slot; it takes effect only at HOLD end.
REQ-028 address and duty_cycle_value SHALL stay constant from the LOAD edge until the next LOAD edge.
REQ-029 A write to the channel in its LOAD cycle SHALL NOT affect that slot; it is applied on the channel's next visit.
REQ-030 Writes are accepted in every state, including IDLE and during reset deassertion's first cycle.
REQ-031 Re-enabling from IDLE always restarts at channel 0.
REQ-032 Slot counter: 24-bit unsigned, never wraps within a legal slot.

Reset
REQ-033 reset_n=0 at a clock edge SHALL force: state IDLE, index 0, address 0, duty_cycle_value 0, latch 0, frame_start 0, busy 0, all shadows = duty_rst.
REQ-034 Reset asserted mid-slot SHALL abort the slot immediately with no further latch pulse.
REQ-035 A write coincident with reset_n=0 SHALL be discarded.

Verification (bench: n_channels=4, slot_cycles=8, duty_min=20, duty_max=200)
REQ-036 Reset, enable=1, no writes -> latch every 8 cycles, address sequence 0,1,2,3,0; duty_cycle_value 128 each; frame_start only with address 0.
REQ-037 Write ch2=300? n/a; write ch2=250 -> ch2 slot shows 200; write ch1=5 -> ch1 slot shows 20; write wr_addr=3 data 90 -> ch3 shows 90.
REQ-038 Write ch1=77 in ch1 LOAD cycle -> current ch1 slot shows old value; next ch1 slot shows 77.
REQ-039 Drop enable 3 cycles into ch2 slot -> slot completes (8 cycles total), busy falls, no further latch; re-enable -> next latch has address 0.
REQ-040 Assert reset_n=0 during ch3 HOLD -> next cycle all outputs zero, busy=0, shadows read back 128 on subsequent scan.
REQ-041 Back-to-back writes ch0=50,ch0=60 on consecutive cycles before ch0 LOAD -> ch0 slot shows 60.
